// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage: PC, imem req/ack fetch, decode hand-off, redirect
//
// Holds the program counter, fetches one word at a time from instruction
// memory and presents it with its PC+4 to decode. Branch, jump and
// jump-register targets from decode redirect the PC while an instruction is held.
//
// Build option: IF_ALIGN_CHECK_EN - when defined, a misaligned redirect target
// raises the sticky Misalign flag and parks the stage in HALT until reset.
// When undefined, target[1:0] is forced to 0 and Misalign is tied 0.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-low reset
//   Imem_req/adr      registered fetch request and word-aligned byte address
//   Imem_ack/rdata    memory response, rdata valid with ack
//   Ins, Pc4          held instruction and its address + 4
//   Ins_valid/ready   hand-off to decode
//   Br_taken, Ed32    conditional branch taken, sign-extended immediate
//   Jmp, Jr, Rdata1   J/JAL, JR and the JR target
//   Misalign          sticky misaligned-target flag
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        Imem_req,
  output logic [31:0] Imem_adr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] Ins,
  output logic [31:0] Pc4,
  output logic        Ins_valid,
  input  logic        Ins_ready,
  input  logic        Br_taken,
  input  logic [31:0] Ed32,
  input  logic        Jmp,
  input  logic        Jr,
  input  logic [31:0] Rdata1,
  output logic        Misalign
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] tgt_raw;
  logic [31:0] tgt;
  logic        redir;
  logic        bad;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (Imem_ack) state_nxt = HOLD;
      HOLD: begin
        if (redir)          state_nxt = bad ? HALT : REQ;
        else if (Ins_ready) state_nxt = REQ;
      end
      default: state_nxt = state;
    endcase
  end

  // Redirect decode and target arithmetic, combinational from held Ins/Pc4
  always_comb begin
    redir = (state == HOLD) && (Jr || Jmp || Br_taken);
    if (Jr)       tgt_raw = Rdata1;
    else if (Jmp) tgt_raw = {Pc4[31:28], Ins[25:0], 2'b00};
    else          tgt_raw = Pc4 + (Ed32 << 2);
`ifdef IF_ALIGN_CHECK_EN
    tgt = tgt_raw;
    bad = redir && (tgt_raw[1:0] != 2'b00);
`else
    tgt = tgt_raw & 32'hFFFF_FFFC;
    bad = 1'b0;
`endif
  end

`ifdef IF_ALIGN_CHECK_EN
  logic misalign_q;
  assign Misalign = misalign_q;
`else
  assign Misalign = 1'b0;
`endif

  // Datapath and registered outputs. Imem_req/Imem_adr are loaded on the
  // edge that enters REQ, so the request is stable for the whole wait.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc        <= RESET_PC;
      Imem_req  <= 1'b0;
      Imem_adr  <= 32'h0;
      Ins       <= 32'h0;
      Pc4       <= 32'h0;
      Ins_valid <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          Imem_req <= 1'b1;
          Imem_adr <= pc;
        end
        REQ: begin
          if (Imem_ack) begin
            Ins       <= Imem_rdata;
            Pc4       <= pc + 32'd4;
            pc        <= pc + 32'd4;
            Ins_valid <= 1'b1;
            Imem_req  <= 1'b0;
          end
        end
        HOLD: begin
          if (redir) begin
            // A redirect consumes the held instruction even without Ins_ready
            Ins_valid <= 1'b0;
            if (!bad) begin
              pc       <= tgt;
              Imem_req <= 1'b1;
              Imem_adr <= tgt;
            end
`ifdef IF_ALIGN_CHECK_EN
            if (bad) misalign_q <= 1'b1;
`endif
          end else if (Ins_ready) begin
            // pc already advanced to Pc4 when the word was accepted
            Ins_valid <= 1'b0;
            Imem_req  <= 1'b1;
            Imem_adr  <= pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - self-checking bench for ifetch with a transaction-level fetch model
module tb_ifetch;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Imem_req;
  logic [31:0] Imem_adr;
  logic        Imem_ack = 1'b0;
  logic [31:0] Imem_rdata = 32'h0;
  logic [31:0] Ins;
  logic [31:0] Pc4;
  logic        Ins_valid;
  logic        Ins_ready = 1'b0;
  logic        Br_taken = 1'b0;
  logic [31:0] Ed32 = 32'h0;
  logic        Jmp = 1'b0;
  logic        Jr = 1'b0;
  logic [31:0] Rdata1 = 32'h0;
  logic        Misalign;

`ifdef IF_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int waits = 2;
  int wcnt = 0;
  logic spur = 1'b0;

  ifetch #(.RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST(RST),
    .Imem_req(Imem_req), .Imem_adr(Imem_adr), .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata),
    .Ins(Ins), .Pc4(Pc4), .Ins_valid(Ins_valid), .Ins_ready(Ins_ready),
    .Br_taken(Br_taken), .Ed32(Ed32), .Jmp(Jmp), .Jr(Jr), .Rdata1(Rdata1),
    .Misalign(Misalign)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0800_0040;
    return a ^ 32'h1234_5678 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: answers a request after 'waits' idle cycles; 'spur' forces an
  // unsolicited ack while no request is outstanding.
  always @(posedge CLK) begin
    #1;
    if (Imem_req && !spur) begin
      if (wcnt >= waits) begin
        Imem_ack   = 1'b1;
        Imem_rdata = mem(Imem_adr);
        wcnt       = 0;
      end else begin
        Imem_ack   = 1'b0;
        wcnt       = wcnt + 1;
      end
    end else begin
      Imem_ack   = spur;
      Imem_rdata = 32'hDEAD_BEEF;
      wcnt       = 0;
    end
  end

  // Model: what the stage must expose, tracked per transaction
  logic        m_started, m_req, m_valid, m_mis, m_halt;
  logic [31:0] m_adr, m_ins, m_pc4, m_t;

  function automatic logic [31:0] tgt_of(input logic [31:0] ins, input logic [31:0] pc4,
                                          input logic jr, input logic jmp,
                                          input logic [31:0] rs, input logic [31:0] imm);
    if (jr)  return rs;
    if (jmp) return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    return pc4 + imm * 4;
  endfunction

  assign m_t = tgt_of(m_ins, m_pc4, Jr, Jmp, Rdata1, Ed32);

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_started <= 1'b0; m_req <= 1'b0; m_valid <= 1'b0; m_mis <= 1'b0; m_halt <= 1'b0;
      m_adr <= 32'h0; m_ins <= 32'h0; m_pc4 <= 32'h0;
    end else if (!m_started) begin
      m_started <= 1'b1;
      m_req     <= 1'b1;
      m_adr     <= 32'h0;
    end else if (m_halt) begin
      m_req <= 1'b0;
    end else if (m_req) begin
      if (Imem_ack) begin
        m_ins   <= mem(m_adr);
        m_pc4   <= m_adr + 32'd4;
        m_valid <= 1'b1;
        m_req   <= 1'b0;
      end
    end else if (m_valid) begin
      if (Jr || Jmp || Br_taken) begin
        m_valid <= 1'b0;
        if (ALIGN && (m_t % 4 != 0)) begin
          m_halt <= 1'b1;
          m_mis  <= 1'b1;
        end else begin
          m_req <= 1'b1;
          m_adr <= m_t & 32'hFFFF_FFFC;
        end
      end else if (Ins_ready) begin
        m_valid <= 1'b0;
        m_req   <= 1'b1;
        m_adr   <= m_pc4;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge CLK) begin
    if (RST) begin
      chk("req", {31'b0, Imem_req}, {31'b0, m_req});
      if (m_req) chk("adr", Imem_adr, m_adr);
      chk("valid", {31'b0, Ins_valid}, {31'b0, m_valid});
      if (m_valid) begin
        chk("ins", Ins, m_ins);
        chk("pc4", Pc4, m_pc4);
      end
      chk("misalign", {31'b0, Misalign}, {31'b0, m_mis});
    end
  end

  task automatic wait_req(input logic [31:0] exp);
    for (int i = 0; i < 50; i++) begin
      if (Imem_req) break;
      @(negedge CLK);
    end
    chk("wait_req", {31'b0, Imem_req}, 32'd1);
    chk("req_adr", Imem_adr, exp);
  endtask

  task automatic wait_hold(input logic [31:0] exp_pc4);
    for (int i = 0; i < 50; i++) begin
      if (Ins_valid) break;
      @(negedge CLK);
    end
    chk("wait_hold", {31'b0, Ins_valid}, 32'd1);
    chk("hold_pc4", Pc4, exp_pc4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    Ins_ready = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_req", {31'b0, Imem_req}, 32'd0);
    chk("rst_adr", Imem_adr, 32'd0);
    chk("rst_ins", Ins, 32'd0);
    chk("rst_pc4", Pc4, 32'd0);
    chk("rst_valid", {31'b0, Ins_valid}, 32'd0);
    chk("rst_mis", {31'b0, Misalign}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("first_req", {31'b0, Imem_req}, 32'd1);

    // Sequential fetch with two wait cycles
    wait_req(32'h0);  wait_hold(32'h4);
    wait_req(32'h4);  wait_hold(32'h8);
    wait_req(32'h8);  wait_hold(32'hC);
    wait_req(32'hC);  wait_hold(32'h10);
    wait_req(32'h10); wait_hold(32'h14);

    // Backward branch from the instruction at 0x10, taken without Ins_ready
    waits = 0;
    Ins_ready = 1'b0; Br_taken = 1'b1; Ed32 = 32'hFFFF_FFFE;
    @(negedge CLK);
    Br_taken = 1'b0; Ed32 = 32'h0;
    chk("br_valid_drop", {31'b0, Ins_valid}, 32'd0);
    wait_req(32'hC);
    wait_hold(32'h10);

    // Stall five cycles, with spurious acks in the middle
    for (int i = 0; i < 5; i++) begin
      if (i == 1) spur = 1'b1;
      if (i == 3) spur = 1'b0;
      @(negedge CLK);
      chk("stall_pc4", Pc4, 32'h10);
      chk("stall_ins", Ins, mem(32'hC));
      chk("stall_req", {31'b0, Imem_req}, 32'd0);
    end
    @(negedge CLK);

    // All redirects at once: Jr wins
    Jr = 1'b1; Jmp = 1'b1; Br_taken = 1'b1; Rdata1 = 32'h400; Ed32 = 32'h5;
    @(negedge CLK);
    Jr = 1'b0; Jmp = 1'b0; Br_taken = 1'b0; Ed32 = 32'h0;
    wait_req(32'h400);
    wait_hold(32'h404);

    // Jump region: fetch J at 0x8000_0000, then take it
    Jr = 1'b1; Rdata1 = 32'h8000_0000;
    @(negedge CLK);
    Jr = 1'b0;
    wait_req(32'h8000_0000);
    wait_hold(32'h8000_0004);
    chk("j_ins", Ins, 32'h0800_0040);
    Jmp = 1'b1;
    @(negedge CLK);
    Jmp = 1'b0;
    wait_req(32'h8000_0100);
    wait_hold(32'h8000_0104);

    // PC wrap from the top word
    Jr = 1'b1; Rdata1 = 32'hFFFF_FFFC;
    @(negedge CLK);
    Jr = 1'b0;
    wait_req(32'hFFFF_FFFC);
    wait_hold(32'h0);
    Ins_ready = 1'b1;
    @(negedge CLK);
    Ins_ready = 1'b0;
    wait_req(32'h0);
    wait_hold(32'h4);

    // Misaligned JR target
    waits = 5;
    Jr = 1'b1; Rdata1 = 32'h402;
    @(negedge CLK);
    Jr = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    chk("mis_set", {31'b0, Misalign}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      Ins_ready = 1'b1;
      @(negedge CLK);
      chk("halt_noreq", {31'b0, Imem_req}, 32'd0);
    end
    Ins_ready = 1'b0;
    RST = 1'b0;
    #1;
    chk("mis_clear", {31'b0, Misalign}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    wait_req(32'h0);
`else
    wait_req(32'h400);
    chk("mis_tied", {31'b0, Misalign}, 32'd0);
`endif

    // Reset while a request is outstanding drops it at once
    RST = 1'b0;
    #1;
    chk("rst_mid_req", {31'b0, Imem_req}, 32'd0);
    chk("rst_mid_adr", Imem_adr, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    waits = 0;
    wait_req(32'h0);
    wait_hold(32'h4);

    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
